// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the fetch-stage PC redirect control slice.
package pc_ctrl_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      RECOVER = 1'b1
   } redirect_state_t;

   localparam int unsigned PC_RESET_VAL           = 0;
   localparam int unsigned DEFAULT_RECOVER_CYCLES = 2;

endpackage

// File: rtl/redirect_pending_buf.sv
// One-entry buffer holding a predictor redirect target that could not be
// applied yet. A set on a full buffer overwrites the held target; clear wins
// over set. Kept as its own block so a second fetch lane can reuse it.
module redirect_pending_buf
   import pc_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             set,
   input  logic             clr,
   input  logic [WIDTH-1:0] set_pc,
   output logic             vld,
   output logic [WIDTH-1:0] pc
);

   // Capture or overwrite the target on set, drop the entry on clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= 1'b0;
         pc  <= WIDTH'(PC_RESET_VAL);
      end else if (clr) begin
         vld <= 1'b0;
      end else if (set) begin
         vld <= 1'b1;
         pc  <= set_pc;
      end
   end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage PC redirect controller. Arbitrates execute-stage mispredicts,
// predictor redirects and fetch stalls, drives the PC register controls and
// pipeline flushes, and keeps a fetch epoch for stale-instruction filtering.
// Optional statistics counters are enabled by defining PC_REDIRECT_STATS_EN.
module pc_redirect_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter int          WIDTH          = 32,
   parameter int unsigned RECOVER_CYCLES = DEFAULT_RECOVER_CYCLES,
   parameter int          EPOCH_W        = 2,
   parameter int          CNT_W          = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall_f_i,
   input  logic               mispredict_i,
   input  logic [WIDTH-1:0]   mispredict_pc_i,
   input  logic               predict_i,
   input  logic [WIDTH-1:0]   predict_pc_i,
   output logic               pc_en_o,
   output logic               pc_redirect_o,
   output logic [WIDTH-1:0]   mispredict_target_pc_o,
   output logic               pc_predict_redirect_o,
   output logic [WIDTH-1:0]   predicted_target_pc_o,
   output logic               flush_fd_o,
   output logic               flush_de_o,
   output logic               recovering_o,
   output logic [EPOCH_W-1:0] epoch_o
`ifdef PC_REDIRECT_STATS_EN
   ,
   output logic [CNT_W-1:0]   mispredict_cnt_o,
   output logic [CNT_W-1:0]   predict_cnt_o
`endif
);

   localparam int RC_W = (RECOVER_CYCLES > 0) ? $clog2(RECOVER_CYCLES + 1) : 1;
   localparam logic [RC_W-1:0] REC_LOAD = RC_W'(RECOVER_CYCLES);

   redirect_state_t  fsm;
   logic [RC_W-1:0]  rec_cnt;
   logic [EPOCH_W-1:0] epoch;
   logic             pend_vld;
   logic [WIDTH-1:0] pend_pc;

   logic mis_take;
   logic pred_take;
   logic pend_take;
   logic pend_set;
   logic pend_clr;

   // Decide which redirect source owns this cycle; everything is gated by
   // reset so the PC register sees all-zero controls while rst_n is low.
   always_comb begin
      mis_take  = 1'b0;
      pred_take = 1'b0;
      pend_take = 1'b0;
      pend_set  = 1'b0;
      pend_clr  = 1'b0;
      if (rst_n) begin
         if (mispredict_i) begin
            mis_take = 1'b1;
            pend_clr = 1'b1;
         end else if (fsm == IDLE) begin
            if (predict_i && !stall_f_i) begin
               pred_take = 1'b1;
               pend_clr  = 1'b1;
            end else if (predict_i && stall_f_i) begin
               pend_set  = 1'b1;
            end else if (pend_vld && !stall_f_i) begin
               pend_take = 1'b1;
               pend_clr  = 1'b1;
            end
         end
      end
   end

   // Drive the PC register controls and flushes from the arbitration result.
   always_comb begin
      pc_en_o                = rst_n & ~stall_f_i;
      pc_redirect_o          = mis_take;
      mispredict_target_pc_o = mis_take ? mispredict_pc_i : '0;
      pc_predict_redirect_o  = pred_take | pend_take;
      predicted_target_pc_o  = '0;
      if (pred_take) begin
         predicted_target_pc_o = predict_pc_i;
      end else if (pend_take) begin
         predicted_target_pc_o = pend_pc;
      end
      flush_fd_o   = mis_take | pred_take | pend_take;
      flush_de_o   = mis_take;
      recovering_o = rst_n & (fsm == RECOVER);
      epoch_o      = rst_n ? epoch : '0;
   end

   // Mispredicts bump the epoch and (re)start the recovery window; the window
   // then counts down every cycle, stalled or not, back to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm     <= IDLE;
         rec_cnt <= '0;
         epoch   <= '0;
      end else if (mispredict_i) begin
         epoch <= epoch + EPOCH_W'(1);
         if (RECOVER_CYCLES > 0) begin
            fsm     <= RECOVER;
            rec_cnt <= REC_LOAD;
         end else begin
            fsm     <= IDLE;
            rec_cnt <= '0;
         end
      end else if (fsm == RECOVER) begin
         rec_cnt <= rec_cnt - RC_W'(1);
         if (rec_cnt == RC_W'(1)) begin
            fsm <= IDLE;
         end
      end
   end

   redirect_pending_buf #(
      .WIDTH(WIDTH)
   ) u_pend (
      .clk   (clk),
      .rst_n (rst_n),
      .set   (pend_set),
      .clr   (pend_clr),
      .set_pc(predict_pc_i),
      .vld   (pend_vld),
      .pc    (pend_pc)
   );

`ifdef PC_REDIRECT_STATS_EN
   logic [CNT_W-1:0] mis_cnt;
   logic [CNT_W-1:0] pred_cnt;

   // Saturating event counters for mispredicts and issued predictor redirects.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mis_cnt  <= '0;
         pred_cnt <= '0;
      end else begin
         if (mispredict_i && (mis_cnt != '1)) begin
            mis_cnt <= mis_cnt + CNT_W'(1);
         end
         if (pc_predict_redirect_o && (pred_cnt != '1)) begin
            pred_cnt <= pred_cnt + CNT_W'(1);
         end
      end
   end

   assign mispredict_cnt_o = mis_cnt;
   assign predict_cnt_o    = pred_cnt;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard testbench for pc_redirect_ctrl: a driver pushes expected outputs
// from a behavioural model, a monitor pops and compares every cycle.
module tb_pc_redirect_ctrl;

   localparam int RC = 2;

   logic        clk;
   logic        rst_n;
   logic        stall_f_i;
   logic        mispredict_i;
   logic [31:0] mispredict_pc_i;
   logic        predict_i;
   logic [31:0] predict_pc_i;
   logic        pc_en_o;
   logic        pc_redirect_o;
   logic [31:0] mispredict_target_pc_o;
   logic        pc_predict_redirect_o;
   logic [31:0] predicted_target_pc_o;
   logic        flush_fd_o;
   logic        flush_de_o;
   logic        recovering_o;
   logic [1:0]  epoch_o;
`ifdef PC_REDIRECT_STATS_EN
   logic [31:0] mispredict_cnt_o;
   logic [31:0] predict_cnt_o;
`endif

   pc_redirect_ctrl #(
      .WIDTH(32), .RECOVER_CYCLES(RC), .EPOCH_W(2), .CNT_W(32)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .stall_f_i             (stall_f_i),
      .mispredict_i          (mispredict_i),
      .mispredict_pc_i       (mispredict_pc_i),
      .predict_i             (predict_i),
      .predict_pc_i          (predict_pc_i),
      .pc_en_o               (pc_en_o),
      .pc_redirect_o         (pc_redirect_o),
      .mispredict_target_pc_o(mispredict_target_pc_o),
      .pc_predict_redirect_o (pc_predict_redirect_o),
      .predicted_target_pc_o (predicted_target_pc_o),
      .flush_fd_o            (flush_fd_o),
      .flush_de_o            (flush_de_o),
      .recovering_o          (recovering_o),
      .epoch_o               (epoch_o)
`ifdef PC_REDIRECT_STATS_EN
      ,
      .mispredict_cnt_o      (mispredict_cnt_o),
      .predict_cnt_o         (predict_cnt_o)
`endif
   );

   typedef struct {
      logic        pc_en;
      logic        redir;
      logic [31:0] mtgt;
      logic        predir;
      logic [31:0] ptgt;
      logic        ffd;
      logic        fde;
      logic        rec;
      logic [1:0]  epoch;
      logic [31:0] mcnt;
      logic [31:0] pcnt;
   } exp_t;

   exp_t expq[$];

   int checks   = 0;
   int failures = 0;

   // Behavioural model state
   int          recLeft;
   int          epochM;
   bit          pendV;
   logic [31:0] pendPc;
   longint      mCnt;
   longint      pCnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic resetModel();
      recLeft = 0;
      epochM  = 0;
      pendV   = 0;
      pendPc  = '0;
      mCnt    = 0;
      pCnt    = 0;
   endtask

   // One fetch cycle: drive inputs after the edge and predict the outputs.
   task automatic applyStimulus(input bit stall, input bit mis, input logic [31:0] mpc,
                                input bit pred, input logic [31:0] ppc);
      exp_t e;
      @(posedge clk);
      #1;
      stall_f_i       = stall;
      mispredict_i    = mis;
      mispredict_pc_i = mpc;
      predict_i       = pred;
      predict_pc_i    = ppc;

      e.pc_en  = !stall;
      e.redir  = 1'b0;
      e.mtgt   = '0;
      e.predir = 1'b0;
      e.ptgt   = '0;
      e.ffd    = 1'b0;
      e.fde    = 1'b0;
      e.rec    = (recLeft > 0);
      e.epoch  = 2'(epochM);
      e.mcnt   = 32'(mCnt);
      e.pcnt   = 32'(pCnt);

      if (mis) begin
         e.redir = 1'b1;
         e.mtgt  = mpc;
         e.ffd   = 1'b1;
         e.fde   = 1'b1;
         epochM  = (epochM + 1) % 4;
         pendV   = 0;
         recLeft = RC;
         if (mCnt < 64'hFFFF_FFFF) mCnt++;
      end else if (recLeft > 0) begin
         recLeft--;
      end else if (pred && !stall) begin
         e.predir = 1'b1;
         e.ptgt   = ppc;
         e.ffd    = 1'b1;
         pendV    = 0;
      end else if (pred && stall) begin
         pendV  = 1;
         pendPc = ppc;
      end else if (pendV && !stall) begin
         e.predir = 1'b1;
         e.ptgt   = pendPc;
         e.ffd    = 1'b1;
         pendV    = 0;
      end
      if (e.predir && pCnt < 64'hFFFF_FFFF) pCnt++;
      expq.push_back(e);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_pc_en"}, 32'(pc_en_o), 32'd0);
      checkOutput({tag, "_redir"}, 32'(pc_redirect_o), 32'd0);
      checkOutput({tag, "_mtgt"}, mispredict_target_pc_o, 32'd0);
      checkOutput({tag, "_predir"}, 32'(pc_predict_redirect_o), 32'd0);
      checkOutput({tag, "_ptgt"}, predicted_target_pc_o, 32'd0);
      checkOutput({tag, "_flush_fd"}, 32'(flush_fd_o), 32'd0);
      checkOutput({tag, "_flush_de"}, 32'(flush_de_o), 32'd0);
      checkOutput({tag, "_recovering"}, 32'(recovering_o), 32'd0);
      checkOutput({tag, "_epoch"}, 32'(epoch_o), 32'd0);
   endtask

   // Monitor: compare the DUT against the oldest expectation each cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            checkOutput("pc_en", 32'(pc_en_o), 32'(e.pc_en));
            checkOutput("pc_redirect", 32'(pc_redirect_o), 32'(e.redir));
            checkOutput("mispredict_target", mispredict_target_pc_o, e.mtgt);
            checkOutput("pc_predict_redirect", 32'(pc_predict_redirect_o), 32'(e.predir));
            checkOutput("predicted_target", predicted_target_pc_o, e.ptgt);
            checkOutput("flush_fd", 32'(flush_fd_o), 32'(e.ffd));
            checkOutput("flush_de", 32'(flush_de_o), 32'(e.fde));
            checkOutput("recovering", 32'(recovering_o), 32'(e.rec));
            checkOutput("epoch", 32'(epoch_o), 32'(e.epoch));
`ifdef PC_REDIRECT_STATS_EN
            checkOutput("mispredict_cnt", mispredict_cnt_o, e.mcnt);
            checkOutput("predict_cnt", predict_cnt_o, e.pcnt);
`endif
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      failures++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int guard;
      resetModel();
      rst_n           = 1'b0;
      stall_f_i       = 1'b0;
      mispredict_i    = 1'b1;
      mispredict_pc_i = 32'h1234;
      predict_i       = 1'b1;
      predict_pc_i    = 32'h5678;
      #1;
      checkAllZero("por");
      #1;
      mispredict_i = 1'b0;
      predict_i    = 1'b0;
      rst_n        = 1'b1;

      $display("[TB] directed: unstalled prediction");
      applyStimulus(0, 0, 0, 1, 32'h40);

      $display("[TB] directed: prediction held across stall");
      repeat (3) applyStimulus(1, 0, 0, 1, 32'h80);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);

      $display("[TB] directed: mispredict with pending prediction and recovery");
      applyStimulus(1, 0, 0, 1, 32'h84);
      applyStimulus(1, 1, 32'h100, 0, 0);
      applyStimulus(0, 0, 0, 1, 32'h200);
      applyStimulus(0, 0, 0, 1, 32'h204);
      applyStimulus(0, 0, 0, 1, 32'h208);
      applyStimulus(0, 0, 0, 0, 0);

      $display("[TB] directed: epoch wrap and recovery restart");
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 32'h300 + 32'(i * 4), 0, 0);
      applyStimulus(0, 0, 0, 1, 32'h400);
      applyStimulus(0, 1, 32'h500, 1, 32'h404);
      applyStimulus(0, 0, 0, 1, 32'h408);
      applyStimulus(1, 0, 0, 1, 32'h40c);
      applyStimulus(0, 0, 0, 1, 32'h410);

      $display("[TB] directed: asynchronous reset mid-recovery");
      guard = 0;
      while (epochM != 3 && guard < 8) begin
         applyStimulus(0, 1, 32'h600, 0, 0);
         guard++;
      end
      applyStimulus(1, 0, 0, 0, 0);
      @(negedge clk);
      #2;
      rst_n           = 1'b0;
      stall_f_i       = 1'b0;
      mispredict_i    = 1'b1;
      predict_i       = 1'b1;
      #1;
      checkAllZero("rst_async");
      @(posedge clk);
      #1;
      checkAllZero("rst_held");
      mispredict_i = 1'b0;
      predict_i    = 1'b0;
      #1;
      rst_n = 1'b1;
      resetModel();

      $display("[TB] random traffic");
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0), $urandom(),
                       ($urandom_range(0, 1) == 1), $urandom());
      end
      applyStimulus(0, 0, 0, 0, 0);

      guard = 0;
      while (expq.size() > 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      #1;
      if (expq.size() > 0) begin
         failures++;
         $display("[TB] FAIL drain: got %0d entries expected 0", expq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
